// File: rtl/suit_pkg.sv
// Package: suit_pkg
// Purpose: types and constants shared by the suit template capture block and the
//          suit matchers. Both sides must agree on the window size and on the
//          row-major address order. That is why the SIZE helper lives here.
// Contents:
//   cap_state_t   - top-level capture/dump FSM states
//   dump_phase_t  - sub-phase used while streaming the stored mask
//   ASCII_*       - characters emitted into the binary memory-init text stream
//   suit_size()   - number of mask bits in one suit window
package suit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    DUMP,
    FIN
  } cap_state_t;

  typedef enum logic [2:0] {
    DP_RD,
    DP_W1,
    DP_BIT,
    DP_NL,
    DP_DRAIN
  } dump_phase_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;
  localparam logic [7:0] ASCII_NL   = 8'h0A;

  function automatic int suit_size(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/suit_template_capture_uart_tx.sv
// Module: uart_tx
// Purpose: 8N1 serial transmitter with a valid/ready byte handshake.
//   A byte is accepted on a cycle where tx_valid && tx_ready.
//   tx_ready stays low from acceptance until the stop bit has finished.
//   Every bit, start and stop included, lasts exactly BAUD_DIV clk cycles.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   tx_data   - byte to send, sampled on acceptance
//   tx_valid  - byte available
//   tx_ready  - transmitter idle and able to accept
//   txd       - serial line; idle high
module uart_tx #(
  parameter int BAUD_DIV = 645
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd
);

  localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] LAST_BAUD = BW'(BAUD_DIV - 1);

  logic          busy_q, busy_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic          txd_q, txd_d;

  // The start bit goes straight into txd_q on acceptance.
  // shift_q holds the data bits followed by a 1, which becomes the stop bit.
  // bit_cnt_q counts the bits already on the line.
  // The value 9 means the stop bit is currently being driven.
  always_comb begin
    busy_d     = busy_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    txd_d      = txd_q;
    if (!busy_q) begin
      if (tx_valid) begin
        busy_d     = 1'b1;
        shift_d    = {1'b1, tx_data};
        txd_d      = 1'b0;
        bit_cnt_d  = 4'd0;
        baud_cnt_d = '0;
      end
    end else if (baud_cnt_q == LAST_BAUD) begin
      baud_cnt_d = '0;
      if (bit_cnt_q == 4'd9) begin
        busy_d = 1'b0;
        txd_d  = 1'b1;
      end else begin
        txd_d     = shift_q[0];
        shift_d   = {1'b1, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      baud_cnt_d = baud_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      shift_q    <= '1;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      txd_q      <= txd_d;
    end
  end

  assign tx_ready = !busy_q;
  assign txd      = txd_q;

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Module: xilinx_true_dual_port_read_first_2_clock_ram
// Purpose: block-RAM style storage for the captured suit mask.
//   Port A is the write port, used during capture.
//   Port B is the read port. It has an array register and an output register,
//   so read data appears two clk cycles after the address is presented.
// Ports:
//   clka, ena, wea, addra, dina - write port
//   clkb, enb, regceb, addrb    - read port controls and address
//   doutb                       - registered read data (2-cycle latency)
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int RAM_WIDTH = 1,
  parameter int RAM_DEPTH = 812,
  parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 ena,
  input  logic                 wea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 clkb,
  input  logic                 enb,
  input  logic                 regceb,
  input  logic [ADDR_W-1:0]    addrb,
  output logic [RAM_WIDTH-1:0] doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_q;
  logic [RAM_WIDTH-1:0] doutb_q;

  always_ff @(posedge clka) begin
    if (ena && wea) begin
      mem[addra] <= dina;
    end
  end

  // The array read and the output register are separate stages. This matches
  // the BRAM primitive when its output register is enabled.
  always_ff @(posedge clkb) begin
    if (enb) begin
      ram_data_q <= mem[addrb];
    end
  end

  always_ff @(posedge clkb) begin
    if (regceb) begin
      doutb_q <= ram_data_q;
    end
  end

  assign doutb = doutb_q;

endmodule

// File: rtl/suit_template_capture.sv
// Module: suit_template_capture
// Purpose: records the binary mask inside one card-corner suit window and
//   streams it over UART as a binary memory-init text file, one bit per line.
//   Each line is '0' or '1' followed by a newline.
//   The bits are written in the same row-major order the suit matchers use.
// Ports:
//   clk, rst    - pixel clock, synchronous active-high reset
//   hcount      - current pixel column (11 bits)
//   vcount      - current pixel row (10 bits)
//   mask        - binarised pixel aligned with hcount/vcount
//   left_edge   - card left edge (11 bits)
//   top_edge    - card top edge (10 bits)
//   capture_req - single-cycle start pulse
//   busy        - high from accepted capture_req until done
//   done        - single-cycle pulse after the last stop bit
//   uart_txd    - 8N1 serial output, idle high
module suit_template_capture
  import suit_pkg::*;
#(
  parameter int CORNER_WIDTH = 28,
  parameter int RANK_HEIGHT  = 40,
  parameter int SUIT_HEIGHT  = 29,
  parameter int X_INSET      = 4,
  parameter int BAUD_DIV     = 645
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        mask,
  input  logic [10:0] left_edge,
  input  logic [9:0]  top_edge,
  input  logic        capture_req,
  output logic        busy,
  output logic        done,
  output logic        uart_txd
);

  localparam int            SIZE      = suit_size(CORNER_WIDTH, SUIT_HEIGHT);
  localparam int            AW        = $clog2(SIZE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);

  cap_state_t  state_q, state_d;
  dump_phase_t phase_q, phase_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          last_q, last_d;
  logic [11:0]   x_lo_q, x_lo_d;
  logic [10:0]   y_lo_q, y_lo_d;

  logic [11:0] x_hi;
  logic [10:0] y_hi;
  logic [11:0] h_ext;
  logic [10:0] v_ext;
  logic        in_window;
  logic        frame_start;
  logic        ram_we;
  logic        ram_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // The window bounds are held in registers, so later changes to
  // left_edge/top_edge do not move the window while a capture is running.
  // The column test is exclusive on the left and inclusive on the right,
  // which matches the matchers' window.
  assign x_hi        = x_lo_q + 12'(CORNER_WIDTH);
  assign y_hi        = y_lo_q + 11'(SUIT_HEIGHT);
  assign h_ext       = {1'b0, hcount};
  assign v_ext       = {1'b0, vcount};
  assign in_window   = (h_ext > x_lo_q) && (h_ext <= x_hi) &&
                       (v_ext >= y_lo_q) && (v_ext < y_hi);
  assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);

  // Next-state logic.
  // CAPTURE: the capture restarts from address 0 at every frame start, so a
  //   window clipped by the frame edge never produces a partial dump.
  // DUMP: the read address moves on as soon as the data byte is accepted.
  //   The next bit then has the whole newline byte time to come out of the
  //   2-cycle RAM pipeline, so bytes stay back-to-back.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    last_d   = last_q;
    x_lo_d   = x_lo_q;
    y_lo_d   = y_lo_q;
    ram_we   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = ASCII_NL;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_req) begin
          state_d = ARM;
          x_lo_d  = {1'b0, left_edge} + 12'(X_INSET);
          y_lo_d  = {1'b0, top_edge} + 11'(RANK_HEIGHT);
          waddr_d = '0;
        end
      end
      ARM: begin
        if (frame_start) begin
          state_d = CAPTURE;
          waddr_d = '0;
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          waddr_d = '0;
        end else if (in_window) begin
          ram_we = 1'b1;
          if (waddr_q == LAST_ADDR) begin
            state_d = DUMP;
            phase_d = DP_RD;
            raddr_d = '0;
            last_d  = 1'b0;
          end else begin
            waddr_d = waddr_q + AW'(1);
          end
        end
      end
      DUMP: begin
        case (phase_q)
          DP_RD: phase_d = DP_W1;
          DP_W1: phase_d = DP_BIT;
          DP_BIT: begin
            tx_valid = 1'b1;
            tx_data  = ram_dout ? ASCII_ONE : ASCII_ZERO;
            if (tx_ready) begin
              phase_d = DP_NL;
              if (raddr_q == LAST_ADDR) begin
                last_d = 1'b1;
              end else begin
                raddr_d = raddr_q + AW'(1);
              end
            end
          end
          DP_NL: begin
            tx_valid = 1'b1;
            tx_data  = ASCII_NL;
            if (tx_ready) begin
              phase_d = last_q ? DP_DRAIN : DP_BIT;
            end
          end
          DP_DRAIN: begin
            if (tx_ready) begin
              state_d = FIN;
            end
          end
          default: phase_d = DP_RD;
        endcase
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= DP_RD;
      waddr_q <= '0;
      raddr_q <= '0;
      last_q  <= 1'b0;
      x_lo_q  <= '0;
      y_lo_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      last_q  <= last_d;
      x_lo_q  <= x_lo_d;
      y_lo_q  <= y_lo_d;
    end
  end

  assign busy = (state_q == ARM) || (state_q == CAPTURE) || (state_q == DUMP);

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH (1),
    .RAM_DEPTH (SIZE),
    .ADDR_W    (AW)
  ) u_ram (
    .clka   (clk),
    .ena    (ram_we),
    .wea    (ram_we),
    .addra  (waddr_q),
    .dina   (mask),
    .clkb   (clk),
    .enb    (1'b1),
    .regceb (1'b1),
    .addrb  (raddr_q),
    .doutb  (ram_dout)
  );

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (uart_txd)
  );

endmodule

// File: tb/tb_suit_template_capture.sv
// Testbench: tb_suit_template_capture
// Scoreboard bench for suit_template_capture.
// The window is scaled down to 6x5 and the frame to 40x30, so each dump is
// 60 bytes instead of 1624 and several captures fit in a short run.
// The address order and the window rules are the same as at full size.
module tb_suit_template_capture;

  localparam int BAUD   = 4;
  localparam int CW     = 6;
  localparam int SH     = 5;
  localparam int RH     = 8;
  localparam int XI     = 4;
  localparam int SIZE   = CW * SH;
  localparam int NBYTES = 2 * SIZE;
  localparam int HT     = 40;
  localparam int VT     = 30;
  localparam int NS     = 10 * BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        mask;
  logic [10:0] left_edge = '0;
  logic [9:0]  top_edge = '0;
  logic        capture_req = 1'b0;
  logic        mask_all = 1'b0;
  logic        busy;
  logic        done;
  logic        uart_txd;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int rx_count = 0;
  int done_count = 0;
  bit mon_active = 1'b0;
  int mon_off = 0;
  logic [NS-1:0] samples;

  suit_template_capture #(
    .CORNER_WIDTH (CW),
    .RANK_HEIGHT  (RH),
    .SUIT_HEIGHT  (SH),
    .X_INSET      (XI),
    .BAUD_DIV     (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .mask        (mask),
    .left_edge   (left_edge),
    .top_edge    (top_edge),
    .capture_req (capture_req),
    .busy        (busy),
    .done        (done),
    .uart_txd    (uart_txd)
  );

  always #5 clk = ~clk;

  // Free-running 40x30 raster.
  // In pattern mode the mask is 1 where (hcount ^ vcount) is odd.
  always @(posedge clk) begin
    if (hcount == 11'(HT - 1)) begin
      hcount <= '0;
      vcount <= (vcount == 10'(VT - 1)) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign mask = mask_all ? 1'b1 : (hcount[0] ^ vcount[0]);

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Decodes one captured frame of 10*BAUD line samples.
  // Every bit slot must hold one level for all of its samples, with a low
  // start bit and a high stop bit. The data bits are read LSB first.
  task automatic checkOutput(input logic [NS-1:0] s);
    logic [7:0] got;
    logic [7:0] exp;
    bit framing_ok;
    framing_ok = 1'b1;
    for (int g = 0; g < 10; g++)
      for (int k = 1; k < BAUD; k++)
        if (s[g*BAUD+k] !== s[g*BAUD]) framing_ok = 1'b0;
    if (s[0] !== 1'b0 || s[9*BAUD] !== 1'b1) framing_ok = 1'b0;
    for (int b = 0; b < 8; b++) got[b] = s[(b+1)*BAUD];
    tests_run++;
    if (!framing_ok) begin
      tests_failed++;
      $display("[TB] FAIL uart_framing byte %0d: samples %b, expected %0d-cycle bits, low start, high stop",
               rx_count, s, BAUD);
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL unexpected_byte %0d: got %h, expected no byte", rx_count, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL byte_value %0d: got %h, expected %h", rx_count, got, exp);
      end
    end
    rx_log.push_back(got);
    rx_count++;
  endtask

  // UART monitor. It samples the line on every falling edge and discards a
  // byte that a reset cuts short.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd === 1'b0) begin
        mon_active = 1'b1;
        samples[0] = 1'b0;
        mon_off = 1;
      end
    end else begin
      samples[mon_off] = uart_txd;
      mon_off++;
      if (mon_off == NS) begin
        mon_active = 1'b0;
        checkOutput(samples);
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  task automatic pulseReq();
    @(negedge clk) capture_req = 1'b1;
    @(negedge clk) capture_req = 1'b0;
  endtask

  // Loads the window and pushes the expected text stream (bit, newline)
  // in row-major order, then issues the request.
  task automatic applyStimulus(input int le, input int te, input bit all_ones);
    int x;
    int y;
    bit b;
    left_edge = 11'(le);
    top_edge  = 10'(te);
    mask_all  = all_ones;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < CW; c++) begin
        x = le + XI + 1 + c;
        y = te + RH + r;
        b = all_ones ? 1'b1 : bit'((x ^ y) & 1);
        exp_q.push_back(b ? 8'h31 : 8'h30);
        exp_q.push_back(8'h0A);
      end
    end
    pulseReq();
  endtask

  task automatic waitDone(input int budget, output bit busy_low);
    bit seen;
    int i;
    seen = 1'b0;
    busy_low = 1'b0;
    i = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_low = 1'b1;
      i++;
    end
    checkVal("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic waitBytes(input int target, input int budget);
    int i;
    i = 0;
    while (rx_count < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    checkVal("bytes_reached", 32'(rx_count >= target), 32'd1);
  endtask

  task automatic endCapture(input int rx_base, input int done_base);
    repeat (5) @(negedge clk);
    checkVal("byte_count", 32'(rx_count - rx_base), 32'(NBYTES));
    checkVal("done_pulses", 32'(done_count - done_base), 32'd1);
    checkVal("queue_drained", 32'(exp_q.size()), 32'd0);
    checkVal("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int rb;
    int db;
    int i;
    bit low;

    repeat (4) @(negedge clk);
    checkVal("reset_busy", 32'(busy), 32'd0);
    checkVal("reset_done", 32'(done), 32'd0);
    checkVal("reset_txd", 32'(uart_txd), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Alternating pattern. The window is x 15..20, y 13..17.
    // Pixel (15,13) is 0 and pixel (16,13) is 1.
    $display("[TB] test 1: alternating pattern");
    rb = rx_count; db = done_count;
    applyStimulus(10, 5, 1'b0);
    waitDone(10000, low);
    endCapture(rb, db);
    if (rx_log.size() >= rb + 4) begin
      checkVal("first_byte_15_13", 32'(rx_log[rb]), 32'h30);
      checkVal("second_byte_nl", 32'(rx_log[rb+1]), 32'h0A);
      checkVal("third_byte_16_13", 32'(rx_log[rb+2]), 32'h31);
      checkVal("fourth_byte_nl", 32'(rx_log[rb+3]), 32'h0A);
    end else begin
      checkVal("first_bytes_present", 32'(rx_log.size() - rb), 32'd4);
    end

    // All-ones mask. busy must not drop before done.
    $display("[TB] test 2: mask held high");
    rb = rx_count; db = done_count;
    applyStimulus(3, 2, 1'b1);
    waitDone(10000, low);
    checkVal("busy_throughout", 32'(low), 32'd0);
    endCapture(rb, db);

    // A second request during the dump is ignored.
    $display("[TB] test 3: request during dump");
    rb = rx_count; db = done_count;
    applyStimulus(20, 10, 1'b0);
    waitBytes(rb + 5, 6000);
    pulseReq();
    waitDone(10000, low);
    endCapture(rb, db);
    repeat (1500) @(negedge clk);
    checkVal("no_restart_bytes", 32'(rx_count - rb), 32'(NBYTES));
    checkVal("no_restart_done", 32'(done_count - db), 32'd1);
    checkVal("idle_after_ignore", 32'(busy), 32'd0);

    // The window lies below the 30-row frame, so the capture never completes.
    $display("[TB] test 4: clipped window");
    rb = rx_count;
    left_edge = 11'd10; top_edge = 10'd24; mask_all = 1'b0;
    pulseReq();
    low = 1'b0;
    for (int k = 0; k < 3 * HT * VT; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) low = 1'b1;
    end
    checkVal("clipped_busy_held", 32'(low), 32'd0);
    checkVal("clipped_no_bytes", 32'(rx_count - rb), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkVal("clipped_rst_busy", 32'(busy), 32'd0);
    checkVal("clipped_rst_txd", 32'(uart_txd), 32'd1);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // A reset inside the start bit of byte 37, then a clean capture.
    $display("[TB] test 5: reset mid-byte");
    rb = rx_count;
    applyStimulus(10, 5, 1'b0);
    waitBytes(rb + 36, 8000);
    i = 0;
    while (uart_txd !== 1'b0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    checkVal("byte37_start_seen", 32'(uart_txd), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checkVal("abort_txd_high", 32'(uart_txd), 32'd1);
    checkVal("abort_busy_low", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rb = rx_count; db = done_count;
    applyStimulus(10, 5, 1'b0);
    waitDone(10000, low);
    endCapture(rb, db);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
